// File: rtl/wq_pkg.sv
// Shared types and constants for the water-quality acquisition front end.
// Holds the reader FSM states, the ADC command bits and the level range.
// No logic of its own beyond the per-period command-bit lookup.
package wq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    DONE
  } adc_state_t;

  // Command bits sent at the head of every frame (single-ended, MSB first)
  localparam logic CMD_START = 1'b1;
  localparam logic CMD_SGL   = 1'b1;
  localparam logic CMD_MSBF  = 1'b1;

  localparam int LEVEL_MAX     = 9;
  localparam int LEVEL_W       = 4;
  localparam int FRAME_PERIODS = 16;
  localparam int NULL_PERIOD   = 4;

  // MOSI value for a given SCLK period; period 2 carries the channel (ODD) bit
  function automatic logic cmd_bit(input logic [3:0] period, input logic ch);
    logic b;
    case (period)
      4'd0:    b = CMD_START;
      4'd1:    b = CMD_SGL;
      4'd2:    b = ch;
      4'd3:    b = CMD_MSBF;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_frame_engine.sv
// Shifts one 16-period SPI frame: drives SCLK/MOSI, samples null bit + result on MISO.
// Latency: done is asserted combinationally on the final SCLK falling edge, 32*CLK_DIV cycles after go.
// No backpressure: once started the frame runs to completion unless reset.
module spi_frame_engine
  import wq_pkg::*;
#(
  parameter int CLK_DIV  = 25,
  parameter int ADC_BITS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic                ch,
  input  logic                miso,
  output logic                sclk,
  output logic                mosi,
  output logic                done,
  output logic                null_bit,
  output logic [ADC_BITS-1:0] result
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [3:0] FIRST_CAP   = 4'(NULL_PERIOD);
  localparam logic [3:0] LAST_CAP    = 4'(NULL_PERIOD + ADC_BITS);
  localparam logic [3:0] LAST_PERIOD = 4'(FRAME_PERIODS - 1);

  logic              active;
  logic [DW-1:0]     div_cnt;
  logic [3:0]        period;
  logic [ADC_BITS:0] shreg;
  logic              half_end;

  assign half_end = active && (div_cnt == DW'(CLK_DIV - 1));
  assign done     = half_end && sclk && (period == LAST_PERIOD);
  // Null bit is the first bit captured, so it ends up at the top of the shifter
  assign null_bit = shreg[ADC_BITS];
  assign result   = shreg[ADC_BITS-1:0];

  // SCLK half-period divider, period counter, MOSI update on falls, MISO capture on rises
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      div_cnt <= '0;
      period  <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      shreg   <= '0;
    end else if (go) begin
      active  <= 1'b1;
      div_cnt <= '0;
      period  <= '0;
      sclk    <= 1'b0;
      mosi    <= cmd_bit(4'd0, ch);
    end else if (active) begin
      if (half_end) begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
          if (period >= FIRST_CAP && period <= LAST_CAP) begin
            shreg <= {shreg[ADC_BITS-1:0], miso};
          end
        end else begin
          sclk <= 1'b0;
          if (period == LAST_PERIOD) begin
            active <= 1'b0;
            mosi   <= 1'b0;
          end else begin
            period <= period + 4'd1;
            mosi   <= cmd_bit(period + 4'd1, ch);
          end
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sensor_adc_reader.sv
// Periodically reads ADC channels 0 (water) and 1 (gas) and quantises each to a 0-9 level.
// Latency: request sampled at edge N -> level_valid in the cycle after edge N+1+68*CLK_DIV.
// Requests arriving while busy collapse into a single pending pair run after the current one.
module sensor_adc_reader
  import wq_pkg::*;
#(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 50000,
  parameter int ADC_BITS      = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                adc_miso,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  output logic                adc_mosi,
  output logic [3:0]          water_level,
  output logic [3:0]          gas_level,
  output logic [ADC_BITS-1:0] water_raw,
  output logic [ADC_BITS-1:0] gas_raw,
  output logic                level_valid,
  output logic                busy,
  output logic                adc_err
);

  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int CW = $clog2(CLK_DIV);

  adc_state_t          state, state_nxt;
  logic [TW-1:0]       tmr;
  logic                tick;
  logic                pending;
  logic                ch;
  logic [CW-1:0]       cnt;
  logic                phase_end;
  logic                eng_go;
  logic                eng_done;
  logic                eng_null;
  logic [ADC_BITS-1:0] eng_result;

  // min(LEVEL_MAX, code*10 / 2^ADC_BITS) with 4 bits of headroom for the x10
  function automatic logic [LEVEL_W-1:0] quantise(input logic [ADC_BITS-1:0] code);
    logic [ADC_BITS+3:0] scaled;
    scaled = ({4'b0000, code} * (ADC_BITS + 4)'(10)) >> ADC_BITS;
    if (scaled > (ADC_BITS + 4)'(LEVEL_MAX)) return LEVEL_W'(LEVEL_MAX);
    return scaled[LEVEL_W-1:0];
  endfunction

  assign tick        = (tmr == TW'(SAMPLE_PERIOD - 1));
  assign phase_end   = (cnt == CW'(CLK_DIV - 1));
  assign adc_cs_n    = !((state == CS_SETUP) || (state == SHIFT));
  assign busy        = (state != IDLE);
  assign level_valid = (state == DONE);

  spi_frame_engine #(
    .CLK_DIV (CLK_DIV),
    .ADC_BITS(ADC_BITS)
  ) u_engine (
    .clk     (clk),
    .rst     (rst),
    .go      (eng_go),
    .ch      (ch),
    .miso    (adc_miso),
    .sclk    (adc_sclk),
    .mosi    (adc_mosi),
    .done    (eng_done),
    .null_bit(eng_null),
    .result  (eng_result)
  );

  // Free-running sample timer, wraps every SAMPLE_PERIOD cycles
  always_ff @(posedge clk) begin
    if (rst || tick) tmr <= '0;
    else             tmr <= tmr + 1'b1;
  end

  // Pending request; a new request wins over the clear so none is lost
  always_ff @(posedge clk) begin
    if (rst)                            pending <= 1'b0;
    else if (tick || start)             pending <= 1'b1;
    else if (state == IDLE && pending)  pending <= 1'b0;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and engine kick-off at the end of chip-select setup
  always_comb begin
    state_nxt = state;
    eng_go    = 1'b0;
    case (state)
      IDLE:     if (pending) state_nxt = CS_SETUP;
      CS_SETUP: if (phase_end) begin
                  state_nxt = SHIFT;
                  eng_go    = 1'b1;
                end
      SHIFT:    if (eng_done) state_nxt = CS_HOLD;
      CS_HOLD:  if (phase_end) state_nxt = ch ? DONE : CS_SETUP;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Setup/hold phase counter, restarted on every state change
  always_ff @(posedge clk) begin
    if (rst || (state_nxt != state))                cnt <= '0;
    else if (state == CS_SETUP || state == CS_HOLD) cnt <= cnt + 1'b1;
  end

  // Channel sequencing: channel 0 first, then channel 1
  always_ff @(posedge clk) begin
    if (rst)                                      ch <= 1'b0;
    else if (state == IDLE && pending)            ch <= 1'b0;
    else if (state == CS_HOLD && phase_end && !ch) ch <= 1'b1;
  end

  // Result capture at frame end; a set null bit keeps the old reading and flags an error
  always_ff @(posedge clk) begin
    if (rst) begin
      water_raw   <= '0;
      gas_raw     <= '0;
      water_level <= '0;
      gas_level   <= '0;
      adc_err     <= 1'b0;
    end else if (state == SHIFT && eng_done) begin
      if (eng_null) begin
        adc_err <= 1'b1;
      end else begin
        adc_err <= 1'b0;
        if (ch) begin
          gas_raw   <= eng_result;
          gas_level <= quantise(eng_result);
        end else begin
          water_raw   <= eng_result;
          water_level <= quantise(eng_result);
        end
      end
    end
  end

endmodule

// File: tb/tb_sensor_adc_reader.sv
// Directed bench for sensor_adc_reader with a behavioural MCP3002-style ADC model.
// Timing is tracked with cyc = number of clock edges since reset was released.
// Each scenario task drives stimulus and checks its own expected values.
module tb_sensor_adc_reader;

  localparam int CLK_DIV       = 2;
  localparam int SAMPLE_PERIOD = 200;
  localparam int ADC_BITS      = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          adc_miso = 1'b0;
  logic          adc_cs_n, adc_sclk, adc_mosi;
  logic [3:0]    water_level, gas_level;
  logic [9:0]    water_raw, gas_raw;
  logic          level_valid, busy, adc_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ADC model state
  logic [9:0] code [2];
  logic       null_err [2];
  int         m_period = 0;
  logic       m_ch = 1'b0;
  logic [3:0] rec_bits = 4'h0;
  logic [3:0] cmd_seen [2];

  int qc [4] = '{0, 102, 103, 921};
  int ql [4] = '{0, 0, 1, 8};
  int gc [4] = '{50, 204, 205, 1000};
  int gl [4] = '{0, 1, 2, 9};

  sensor_adc_reader #(
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .ADC_BITS     (ADC_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .adc_miso   (adc_miso),
    .adc_cs_n   (adc_cs_n),
    .adc_sclk   (adc_sclk),
    .adc_mosi   (adc_mosi),
    .water_level(water_level),
    .gas_level  (gas_level),
    .water_raw  (water_raw),
    .gas_raw    (gas_raw),
    .level_valid(level_valid),
    .busy       (busy),
    .adc_err    (adc_err)
  );

  always #5 clk = ~clk;

  // ADC model: record command bits on rising SCLK
  always @(posedge adc_sclk) begin
    if (m_period < 4) rec_bits[3 - m_period] = adc_mosi;
    if (m_period == 2) m_ch = adc_mosi;
  end

  // ADC model: advance period and present next MISO bit on falling SCLK
  always @(negedge adc_sclk or posedge adc_cs_n) begin
    if (adc_cs_n === 1'b1) begin
      m_period = 0;
      adc_miso = 1'b0;
    end else if (adc_cs_n === 1'b0) begin
      m_period++;
      if (m_period == 4) begin
        cmd_seen[m_ch] = rec_bits;
        adc_miso = null_err[m_ch];
      end else if (m_period >= 5 && m_period <= 14) begin
        adc_miso = code[m_ch][14 - m_period];
      end else begin
        adc_miso = 1'b0;
      end
    end
  end

  task automatic tick_clk();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) tick_clk();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick_clk();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < limit && !ok) begin
      tick_clk();
      n++;
      if (level_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    int odd;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) tick_clk();
    total++;
    if ({adc_cs_n, adc_sclk, adc_mosi, busy, level_valid, adc_err} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=100000",
               {adc_cs_n, adc_sclk, adc_mosi, busy, level_valid, adc_err});
    end
    total++;
    if ({water_level, gas_level, water_raw, gas_raw} !== 28'h0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0", {water_level, gas_level, water_raw, gas_raw});
    end
    rst = 1'b0;
    cyc = 0;
    odd = 0;
    repeat (60) begin
      tick_clk();
      if (level_valid !== 1'b0 || adc_cs_n !== 1'b1 || busy !== 1'b0) odd++;
    end
    total++;
    if (odd != 0) begin
      bad++;
      $display("FAIL reset_quiet got=%0d active cycles want=0", odd);
    end
  endtask

  task automatic test_manual_start();
    bit ok;
    do_reset();
    code[0] = 10'd512;
    code[1] = 10'd1023;
    null_err[0] = 1'b0;
    null_err[1] = 1'b0;
    pulse_start();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_before_accept got=%b want=0", busy);
    end
    tick_clk();
    total++;
    if ({adc_cs_n, busy} !== 2'b01) begin
      bad++;
      $display("FAIL accept_cs_busy got=%b want=01", {adc_cs_n, busy});
    end
    wait_valid(300, ok);
    total++;
    if (!ok || (cyc - 1) != 137) begin
      bad++;
      $display("FAIL valid_latency got=%0d (seen=%0d) want=137", cyc - 1, ok);
    end
    total++;
    if (water_raw !== 10'd512 || water_level !== 4'd5) begin
      bad++;
      $display("FAIL water_512 got=%0d/%0d want=512/5", water_raw, water_level);
    end
    total++;
    if (gas_raw !== 10'd1023 || gas_level !== 4'd9) begin
      bad++;
      $display("FAIL gas_1023 got=%0d/%0d want=1023/9", gas_raw, gas_level);
    end
    total++;
    if (cmd_seen[0] !== 4'b1101 || cmd_seen[1] !== 4'b1111) begin
      bad++;
      $display("FAIL mosi_cmd got=%b/%b want=1101/1111", cmd_seen[0], cmd_seen[1]);
    end
    tick_clk();
    total++;
    if ({level_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL valid_one_cycle got=%b want=00", {level_valid, busy});
    end
  endtask

  task automatic test_quantiser();
    bit ok;
    for (int i = 0; i < 4; i++) begin
      do_reset();
      code[0] = 10'(qc[i]);
      code[1] = 10'(gc[i]);
      pulse_start();
      wait_valid(300, ok);
      total++;
      if (!ok || water_level !== 4'(ql[i]) || water_raw !== 10'(qc[i])) begin
        bad++;
        $display("FAIL quant_water code=%0d got=%0d/%0d want=%0d", qc[i], water_raw, water_level, ql[i]);
      end
      total++;
      if (!ok || gas_level !== 4'(gl[i])) begin
        bad++;
        $display("FAIL quant_gas code=%0d got=%0d want=%0d", gc[i], gas_level, gl[i]);
      end
      total++;
      if (cmd_seen[0] !== 4'b1101 || cmd_seen[1] !== 4'b1111) begin
        bad++;
        $display("FAIL quant_mosi got=%b/%b want=1101/1111", cmd_seen[0], cmd_seen[1]);
      end
    end
  endtask

  task automatic test_null_error();
    bit ok;
    do_reset();
    code[0] = 10'd512;
    code[1] = 10'd1023;
    null_err[0] = 1'b0;
    null_err[1] = 1'b0;
    pulse_start();
    wait_valid(300, ok);
    code[0] = 10'd300;
    code[1] = 10'd100;
    null_err[1] = 1'b1;
    pulse_start();
    wait_valid(300, ok);
    total++;
    if (!ok || adc_err !== 1'b1) begin
      bad++;
      $display("FAIL null_err_flag got=%b (seen=%0d) want=1", adc_err, ok);
    end
    total++;
    if (gas_raw !== 10'd1023 || gas_level !== 4'd9) begin
      bad++;
      $display("FAIL null_gas_hold got=%0d/%0d want=1023/9", gas_raw, gas_level);
    end
    total++;
    if (water_raw !== 10'd300 || water_level !== 4'd2) begin
      bad++;
      $display("FAIL null_water_update got=%0d/%0d want=300/2", water_raw, water_level);
    end
    null_err[1] = 1'b0;
    code[1] = 10'd716;
    pulse_start();
    wait_valid(400, ok);
    total++;
    if (!ok || adc_err !== 1'b0 || gas_raw !== 10'd716 || gas_level !== 4'd6) begin
      bad++;
      $display("FAIL null_err_clear got=%b %0d/%0d want=0 716/6", adc_err, gas_raw, gas_level);
    end
  endtask

  task automatic test_collapse();
    bit ok;
    int quiet;
    int sp [3] = '{120, 150, 180};
    do_reset();
    code[0] = 10'd256;
    code[1] = 10'd768;
    while (cyc < 98) tick_clk();
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      while (cyc < sp[k] - 1) tick_clk();
      pulse_start();
    end
    wait_valid(300, ok);
    total++;
    if (!ok || cyc != 236) begin
      bad++;
      $display("FAIL first_pair_end got=%0d want=236", cyc);
    end
    tick_clk();
    total++;
    if ({adc_cs_n, busy} !== 2'b10) begin
      bad++;
      $display("FAIL gap_idle got=%b want=10", {adc_cs_n, busy});
    end
    tick_clk();
    total++;
    if ({adc_cs_n, busy} !== 2'b01) begin
      bad++;
      $display("FAIL second_pair_start got=%b want=01", {adc_cs_n, busy});
    end
    wait_valid(300, ok);
    total++;
    if (!ok || cyc != 374 || water_level !== 4'd2 || gas_level !== 4'd7) begin
      bad++;
      $display("FAIL second_pair_end got=%0d lv=%0d/%0d want=374 2/7", cyc, water_level, gas_level);
    end
    quiet = 0;
    while (cyc < 400) begin
      tick_clk();
      if (adc_cs_n !== 1'b1 || busy !== 1'b0 || level_valid !== 1'b0) quiet++;
    end
    total++;
    if (quiet != 0) begin
      bad++;
      $display("FAIL no_third_pair got=%0d active cycles want=0", quiet);
    end
    tick_clk();
    total++;
    if (adc_cs_n !== 1'b0) begin
      bad++;
      $display("FAIL timer_pair_start got=%b want=0", adc_cs_n);
    end
    wait_valid(300, ok);
    total++;
    if (!ok || cyc != 537) begin
      bad++;
      $display("FAIL timer_pair_end got=%0d want=537", cyc);
    end
    while (cyc < 600) tick_clk();
    total++;
    if (adc_cs_n !== 1'b1) begin
      bad++;
      $display("FAIL timer_gap got=%b want=1", adc_cs_n);
    end
    tick_clk();
    total++;
    if (adc_cs_n !== 1'b0) begin
      bad++;
      $display("FAIL timer_period got=%b want=0", adc_cs_n);
    end
  endtask

  task automatic test_reset_mid_shift();
    bit ok;
    int odd;
    do_reset();
    code[0] = 10'd512;
    code[1] = 10'd1023;
    pulse_start();
    wait_valid(300, ok);
    pulse_start();
    while (cyc < 175) tick_clk();
    total++;
    if (adc_cs_n !== 1'b0 || busy !== 1'b1 || water_level !== 4'd5) begin
      bad++;
      $display("FAIL pre_reset_shift got=%b%b lv=%0d want=01 lv=5", adc_cs_n, busy, water_level);
    end
    rst = 1'b1;
    tick_clk();
    total++;
    if ({adc_cs_n, adc_sclk, adc_mosi, busy, level_valid, adc_err} !== 6'b100000) begin
      bad++;
      $display("FAIL mid_reset_ctrl got=%b want=100000",
               {adc_cs_n, adc_sclk, adc_mosi, busy, level_valid, adc_err});
    end
    total++;
    if ({water_level, gas_level, water_raw, gas_raw} !== 28'h0) begin
      bad++;
      $display("FAIL mid_reset_data got=%h want=0", {water_level, gas_level, water_raw, gas_raw});
    end
    rst = 1'b0;
    odd = 0;
    repeat (150) begin
      tick_clk();
      if (level_valid !== 1'b0 || adc_cs_n !== 1'b1) odd++;
    end
    total++;
    if (odd != 0) begin
      bad++;
      $display("FAIL mid_reset_discard got=%0d active cycles want=0", odd);
    end
  endtask

  initial begin
    null_err[0] = 1'b0;
    null_err[1] = 1'b0;
    code[0] = 10'd0;
    code[1] = 10'd0;
    test_reset();
    test_manual_start();
    test_quantiser();
    test_null_error();
    test_collapse();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
